// File: rtl/hazard_scheduler_pkg.sv
// Shared types and helpers for the pipeline hazard scheduler.
package hazard_scheduler_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;

  // Operand source selects driven to the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // One tracked in-flight writer.
  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      we;
    logic                      is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // A writer is a forwarding candidate only if it really writes a non-x0 register.
  function automatic logic sb_match(input sb_entry_t e,
                                    input logic [DEF_REG_ADDR_W-1:0] r);
    return e.valid & e.we & (e.rd != '0) & (e.rd == r);
  endfunction

  // Youngest writer wins; an EX load is left to the load-use stall instead.
  function automatic fwd_sel_e fwd_pick(input logic en,
                                        input logic [DEF_REG_ADDR_W-1:0] r,
                                        input sb_entry_t ex,
                                        input sb_entry_t mem,
                                        input sb_entry_t wb);
    if (!en)                             return FWD_RF;
    if (sb_match(ex, r) && !ex.is_load)  return FWD_EX;
    if (sb_match(mem, r))                return FWD_MEM;
    if (sb_match(wb, r))                 return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: advance on enable unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard scheduler: tracks EX/MEM/WB writers, drives forwarding, load-use stall and flushes.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_use_r1_i,
  input  logic                  id_use_r2_i,
  input  logic                  id_reg_we_i,
  input  logic                  id_is_load_i,
  input  logic                  ex_redirect_i,
  output logic                  stall_o,
  output logic                  flush_if_id_o,
  output logic                  flush_id_ex_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q, wb_d;
  logic      load_use;

  // Hazard detection, control outputs and scoreboard advance.
  always_comb begin
    load_use = id_valid_i &
               ((id_use_r1_i & sb_match(ex_q, id_rs1_i) & ex_q.is_load) |
                (id_use_r2_i & sb_match(ex_q, id_rs2_i) & ex_q.is_load));

    // Redirect wins over load-use: the ID instruction is on the wrong path.
    stall_o       = load_use & ~ex_redirect_i;
    flush_id_ex_o = load_use | ex_redirect_i;
    flush_if_id_o = ex_redirect_i;

    fwd_a_sel_o = fwd_pick(id_valid_i & id_use_r1_i, id_rs1_i, ex_q, mem_q, wb_q);
    fwd_b_sel_o = fwd_pick(id_valid_i & id_use_r2_i, id_rs2_i, ex_q, mem_q, wb_q);

    ex_d = SB_EMPTY;
    if (!flush_id_ex_o) begin
      ex_d.valid   = id_valid_i;
      ex_d.rd      = id_rd_i;
      ex_d.we      = id_reg_we_i;
      ex_d.is_load = id_is_load_i;
    end
    // Older stages drain even while ID is stalled.
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  // Scoreboard registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      wb_q  <= SB_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (stall_o),
    .cnt_o   (stall_cnt_o)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (ex_redirect_i),
    .cnt_o   (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: stimulus pushes expectations, a monitor checks them.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_r1, id_use_r2, id_reg_we, id_is_load, ex_redirect;

  logic        stall, flush_if_id, flush_id_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        stall2, flush_if_id2, flush_id_ex2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  always #5 clk = ~clk;

  hazard_scheduler #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_use_r1_i(id_use_r1), .id_use_r2_i(id_use_r2),
    .id_reg_we_i(id_reg_we), .id_is_load_i(id_is_load),
    .ex_redirect_i(ex_redirect),
    .stall_o(stall), .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Narrow-counter copy to exercise saturation.
  hazard_scheduler #(.REG_ADDR_W(5), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_use_r1_i(id_use_r1), .id_use_r2_i(id_use_r2),
    .id_reg_we_i(id_reg_we), .id_is_load_i(id_is_load),
    .ex_redirect_i(ex_redirect),
    .stall_o(stall2), .flush_if_id_o(flush_if_id2), .flush_id_ex_o(flush_id_ex2),
    .fwd_a_sel_o(fwd_a2), .fwd_b_sel_o(fwd_b2),
    .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
  );

  typedef struct {
    logic        stall, fif, fide;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc, sc2, fc2;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_sc = 0, exp_fc = 0, exp_sc2 = 0, exp_fc2 = 0;
  string       tag = "reset";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s [%s] @%0t: got %0h, expected %0h", name, tag, $time, act, req);
    end
  endtask

  // Monitor: every negedge, compare the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall",       32'(stall),       32'(e.stall));
      chk("flush_if_id", 32'(flush_if_id), 32'(e.fif));
      chk("flush_id_ex", 32'(flush_id_ex), 32'(e.fide));
      chk("fwd_a",       32'(fwd_a),       32'(e.fa));
      chk("fwd_b",       32'(fwd_b),       32'(e.fb));
      chk("stall_cnt",   32'(stall_cnt),   e.sc);
      chk("flush_cnt",   32'(flush_cnt),   e.fc);
      chk("stall_cnt_w2", 32'(stall_cnt2), e.sc2);
      chk("flush_cnt_w2", 32'(flush_cnt2), e.fc2);
    end
  end

  // Present one ID-stage instruction for a cycle and queue its expected response.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic we, input logic ld, input logic rdr,
                       input logic es, input logic efif, input logic efide,
                       input logic [1:0] efa, input logic [1:0] efb);
    exp_t x;
    @(posedge clk); #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_r1 = u1; id_use_r2 = u2; id_reg_we = we; id_is_load = ld;
    ex_redirect = rdr;
    x.stall = es; x.fif = efif; x.fide = efide; x.fa = efa; x.fb = efb;
    x.sc = exp_sc; x.fc = exp_fc; x.sc2 = exp_sc2; x.fc2 = exp_fc2;
    expq.push_back(x);
    if (es) begin
      if (exp_sc < 32'hFFFF) exp_sc++;
      if (exp_sc2 < 3) exp_sc2++;
    end
    if (rdr) begin
      if (exp_fc < 32'hFFFF) exp_fc++;
      if (exp_fc2 < 3) exp_fc2++;
    end
  endtask

  task automatic bubble();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_r1 = 0; id_use_r2 = 0; id_reg_we = 0; id_is_load = 0; ex_redirect = 0;

    // Reset: hazard-looking inputs must not produce anything.
    issue(1, 7, 7, 8, 1, 1, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    @(negedge clk); #1 rst_n = 1'b1;
    bubble();

    // Back-to-back ALU: add x5,x1,x2 ; sub x6,x5,x3
    tag = "alu_ex";
    issue(1, 1, 2, 5, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 5, 3, 6, 1, 1, 1, 0, 0,  0, 0, 0, 2'b01, 2'b00);
    // One independent instruction between
    tag = "alu_mem";
    issue(1, 1, 2, 5, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 11, 12, 10, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 5, 3, 6, 1, 1, 1, 0, 0,  0, 0, 0, 2'b10, 2'b00);
    // Two independent instructions between
    tag = "alu_wb";
    issue(1, 1, 2, 5, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 12, 13, 11, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 13, 14, 12, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 5, 3, 6, 1, 1, 1, 0, 0,  0, 0, 0, 2'b11, 2'b00);
    bubble(); bubble(); bubble();

    // Load-use: lw x7,0(x1) ; add x8,x7,x7 (stalls once, then MEM forward)
    tag = "load_use";
    issue(1, 1, 0, 7, 1, 0, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  1, 0, 1, 2'b00, 2'b00);
    issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10);
    bubble(); bubble(); bubble();

    // x0 writers never forward or stall
    tag = "x0";
    issue(1, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 0, 0, 9, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 1, 0, 0, 1, 0, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 0, 0, 9, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    bubble(); bubble(); bubble();

    // Redirect colliding with load-use: no stall, both flushes, flush count only
    tag = "redirect";
    issue(1, 1, 0, 7, 1, 0, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 7, 7, 8, 1, 1, 1, 0, 1,  0, 1, 1, 2'b00, 2'b00);
    bubble();
    issue(1, 3, 4, 9, 1, 1, 1, 0, 1,  0, 1, 1, 2'b00, 2'b00);
    bubble(); bubble(); bubble();

    // Priority: x5 in EX and MEM -> EX; store reads x5 on both operands
    tag = "priority";
    issue(1, 1, 2, 5, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 3, 4, 5, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 5, 5, 0, 1, 1, 0, 0, 0,  0, 0, 0, 2'b01, 2'b01);
    issue(1, 5, 5, 1, 1, 1, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10);
    issue(1, 5, 5, 0, 0, 1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b11);
    bubble(); bubble(); bubble();

    // Saturation: five more load-use stalls; 2-bit counter pins at 3
    tag = "saturate";
    for (int i = 0; i < 5; i++) begin
      issue(1, 1, 0, 7, 1, 0, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
      issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  1, 0, 1, 2'b00, 2'b00);
      issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10);
    end

    // Asynchronous reset in the middle of a stall cycle
    tag = "async_reset";
    issue(1, 1, 0, 7, 1, 0, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  1, 0, 1, 2'b00, 2'b00);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_stall",       32'(stall),       32'd0);
    chk("rst_flush_id_ex", 32'(flush_id_ex), 32'd0);
    chk("rst_fwd_a",       32'(fwd_a),       32'd0);
    chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);
    chk("rst_flush_cnt",   32'(flush_cnt),   32'd0);
    chk("rst_stall_cnt_w2", 32'(stall_cnt2), 32'd0);
    exp_sc = 0; exp_fc = 0; exp_sc2 = 0; exp_fc2 = 0;
    bubble(); bubble();
    @(negedge clk); #1 rst_n = 1'b1;
    // The load tracked before reset is gone
    tag = "post_reset";
    issue(1, 7, 7, 8, 1, 1, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
    issue(1, 8, 7, 9, 1, 1, 1, 0, 0,  0, 0, 0, 2'b01, 2'b00);

    repeat (3) @(posedge clk);
    tag = "drain";
    chk("queue_drain", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
